// File: rtl/dds_pkg.sv
// Shared definitions for the DDS serial-load receiver: frame geometry,
// field offsets inside the 40-bit tuning word and the receiver FSM states.
package dds_pkg;

  localparam int DDS_WORD_W = 40;
  localparam int FREQ_LSB   = 0;
  localparam int CTRL_LSB   = 32;
  localparam int PD_BIT     = 34;
  localparam int PHASE_LSB  = 35;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } dds_rx_state_t;

endpackage

// File: rtl/dds_serial_rx_if.sv
// DDS serial pins plus the decoded word/status returned by the receiver.
// master drives the pins and watches the results; slave is the receiver.
interface dds_serial_rx_if;

  logic        dds_reset;
  logic        w_clk;
  logic        fq_ud;
  logic        data;
  logic        err_clr;
  logic [31:0] freq_word;
  logic [1:0]  ctrl;
  logic        pwr_down;
  logic [4:0]  phase;
  logic        word_valid;
  logic        reload;
  logic [7:0]  frame_cnt;
  logic        err_short;
  logic        err_over;

  modport master (
    output dds_reset, w_clk, fq_ud, data, err_clr,
    input  freq_word, ctrl, pwr_down, phase, word_valid, reload,
           frame_cnt, err_short, err_over
  );

  modport slave (
    input  dds_reset, w_clk, fq_ud, data, err_clr,
    output freq_word, ctrl, pwr_down, phase, word_valid, reload,
           frame_cnt, err_short, err_over
  );

endinterface

// File: rtl/dds_pin_sync.sv
// Synchronizer for one DDS pin. level and rise are both registered one stage
// past the synchronizer so every pin instance presents aligned samples.
module dds_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_r;
  logic              level_r;
  logic              rise_r;

  // synchronizer chain, aligned level copy and registered rising-edge detect
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_r  <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[STAGES-2:0], pin};
      level_r <= sync_r[STAGES-1];
      rise_r  <= sync_r[STAGES-1] & ~level_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/dds_serial_rx.sv
// DDS serial-load receiver: rebuilds the LSB-first tuning word from the
// oversampled pins, commits it on fq_ud and flags short/over-length frames.
module dds_serial_rx
  import dds_pkg::*;
#(
  parameter int WORD_W      = DDS_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_sys,
  input  logic            rst,
  dds_serial_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic              rst_lvl_s, w_rise_s, fq_rise_s, data_lvl_s;
  logic              w_lvl_unused_s, fq_lvl_unused_s;
  logic              rst_rise_unused_s, data_rise_unused_s;
  logic              set_short_s, set_over_s;

  dds_rx_state_t     state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [WORD_W-1:0] shreg_r;
  logic [31:0]       freq_word_r;
  logic [1:0]        ctrl_r;
  logic              pwr_down_r;
  logic [4:0]        phase_r;
  logic              word_valid_r, reload_r;
  logic [7:0]        frame_cnt_r;
  logic              err_short_r, err_over_r;

  dds_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk_sys(clk_sys), .rst(rst), .pin(bus.dds_reset),
    .level(rst_lvl_s), .rise(rst_rise_unused_s));
  dds_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_wclk (
    .clk_sys(clk_sys), .rst(rst), .pin(bus.w_clk),
    .level(w_lvl_unused_s), .rise(w_rise_s));
  dds_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_fqud (
    .clk_sys(clk_sys), .rst(rst), .pin(bus.fq_ud),
    .level(fq_lvl_unused_s), .rise(fq_rise_s));
  dds_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk_sys(clk_sys), .rst(rst), .pin(bus.data),
    .level(data_lvl_s), .rise(data_rise_unused_s));

  // error events; a w_clk edge landing with fq_ud counts as an overrun
  always_comb begin
    set_short_s = 1'b0;
    set_over_s  = 1'b0;
    if (rst_lvl_s) begin
      set_short_s = 1'b0;
      set_over_s  = 1'b0;
    end else begin
      set_short_s = fq_rise_s && (state_r == SHIFT);
      set_over_s  = w_rise_s && (fq_rise_s || (state_r == FULL));
    end
  end

  // receive FSM, shift register, committed fields and status
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      shreg_r      <= '0;
      freq_word_r  <= 32'd0;
      ctrl_r       <= 2'd0;
      pwr_down_r   <= 1'b0;
      phase_r      <= 5'd0;
      word_valid_r <= 1'b0;
      reload_r     <= 1'b0;
      frame_cnt_r  <= 8'd0;
      err_short_r  <= 1'b0;
      err_over_r   <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      reload_r     <= 1'b0;
      err_short_r  <= set_short_s | (err_short_r & ~bus.err_clr);
      err_over_r   <= set_over_s  | (err_over_r  & ~bus.err_clr);
      if (rst_lvl_s) begin
        state_r     <= IDLE;
        cnt_r       <= '0;
        shreg_r     <= '0;
        freq_word_r <= 32'd0;
        ctrl_r      <= 2'd0;
        pwr_down_r  <= 1'b0;
        phase_r     <= 5'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (fq_rise_s) begin
              reload_r <= 1'b1;
            end else if (w_rise_s) begin
              shreg_r <= {data_lvl_s, shreg_r[WORD_W-1:1]};
              cnt_r   <= CNT_W'(1);
              state_r <= SHIFT;
            end
          end
          SHIFT: begin
            if (fq_rise_s) begin
              cnt_r   <= '0;
              state_r <= IDLE;
            end else if (w_rise_s) begin
              shreg_r <= {data_lvl_s, shreg_r[WORD_W-1:1]};
              cnt_r   <= cnt_r + CNT_W'(1);
              if (cnt_r == CNT_W'(WORD_W - 1)) begin
                state_r <= FULL;
              end
            end
          end
          FULL: begin
            // extra w_clk bits are dropped here; only fq_ud leaves FULL
            if (fq_rise_s) begin
              freq_word_r  <= shreg_r[FREQ_LSB +: 32];
              ctrl_r       <= shreg_r[CTRL_LSB +: 2];
              pwr_down_r   <= shreg_r[PD_BIT];
              phase_r      <= shreg_r[PHASE_LSB +: 5];
              word_valid_r <= 1'b1;
              frame_cnt_r  <= frame_cnt_r + 8'd1;
              cnt_r        <= '0;
              state_r      <= IDLE;
            end
          end
          default: begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.freq_word  = freq_word_r;
  assign bus.ctrl       = ctrl_r;
  assign bus.pwr_down   = pwr_down_r;
  assign bus.phase      = phase_r;
  assign bus.word_valid = word_valid_r;
  assign bus.reload     = reload_r;
  assign bus.frame_cnt  = frame_cnt_r;
  assign bus.err_short  = err_short_r;
  assign bus.err_over   = err_over_r;

endmodule

// File: tb/tb_dds_serial_rx.sv
// Directed bench for dds_serial_rx: frames, framing errors, dds_reset,
// reload and asynchronous rst, checked against hand-computed values.
module tb_dds_serial_rx;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   wv_cnt  = 0;
  int   rl_cnt  = 0;
  int   both_cnt = 0;

  dds_serial_rx_if bus ();

  dds_serial_rx dut (
    .clk_sys(clk_sys),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (!rst) begin
      if (bus.word_valid) wv_cnt++;
      if (bus.reload) rl_cnt++;
      if (bus.word_valid && bus.reload) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    bus.data = b;
    cyc(3);
    bus.w_clk = 1'b1;
    cyc(3);
    bus.w_clk = 1'b0;
    cyc(3);
  endtask

  task automatic send_bits(input logic [40:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic pulse_fq();
    bus.fq_ud = 1'b1;
    cyc(3);
    bus.fq_ud = 1'b0;
    cyc(6);
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    int wv0, rl0;
    bus.dds_reset = 1'b0;
    bus.w_clk     = 1'b0;
    bus.fq_ud     = 1'b0;
    bus.data      = 1'b0;
    bus.err_clr   = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // reset state
    chk("rst_freq", {8'd0, bus.freq_word}, 40'd0);
    chk("rst_cnt", {32'd0, bus.frame_cnt}, 40'd0);
    chk("rst_errs", {38'd0, bus.err_short, bus.err_over}, 40'd0);

    // frame A: freq 12345678, phase 0A
    wv0 = wv_cnt;
    send_bits({1'b0, 40'h50_12345678}, 40);
    pulse_fq();
    chk("a_freq", {8'd0, bus.freq_word}, 40'h12345678);
    chk("a_phase", {35'd0, bus.phase}, 40'h0A);
    chk("a_ctrl_pd", {37'd0, bus.ctrl, bus.pwr_down}, 40'd0);
    chk("a_wv", 40'(wv_cnt - wv0), 40'd1);
    chk("a_cnt", {32'd0, bus.frame_cnt}, 40'd1);
    chk("a_errs", {38'd0, bus.err_short, bus.err_over}, 40'd0);

    // 39 bits then fq_ud: short frame, nothing committed
    wv0 = wv_cnt;
    send_bits({1'b0, 40'hAF_CAFEBABE}, 39);
    pulse_fq();
    chk("short_err", {39'd0, bus.err_short}, 40'd1);
    chk("short_freq", {8'd0, bus.freq_word}, 40'h12345678);
    chk("short_cnt", {32'd0, bus.frame_cnt}, 40'd1);
    chk("short_wv", 40'(wv_cnt - wv0), 40'd0);

    // frame B commits normally; short flag stays sticky
    send_bits({1'b0, 40'hAF_CAFEBABE}, 40);
    pulse_fq();
    chk("b_freq", {8'd0, bus.freq_word}, 40'hCAFEBABE);
    chk("b_fields", {32'd0, bus.phase, bus.pwr_down, bus.ctrl}, {32'd0, 5'h15, 1'b1, 2'd3});
    chk("b_cnt", {32'd0, bus.frame_cnt}, 40'd2);
    chk("b_short_sticky", {39'd0, bus.err_short}, 40'd1);
    pulse_err_clr();
    chk("clr_short", {39'd0, bus.err_short}, 40'd0);

    // 41 bits: overrun, first 40 committed
    wv0 = wv_cnt;
    send_bits({1'b1, 40'hF9_0F0F0F0F}, 41);
    pulse_fq();
    chk("over_err", {39'd0, bus.err_over}, 40'd1);
    chk("over_freq", {8'd0, bus.freq_word}, 40'h0F0F0F0F);
    chk("over_fields", {32'd0, bus.phase, bus.pwr_down, bus.ctrl}, {32'd0, 5'h1F, 1'b0, 2'd1});
    chk("over_wv", 40'(wv_cnt - wv0), 40'd1);
    chk("over_cnt", {32'd0, bus.frame_cnt}, 40'd3);
    pulse_err_clr();
    chk("clr_over", {39'd0, bus.err_over}, 40'd0);

    // coincident w_clk / fq_ud after 40 bits; the extra bit is dropped
    wv0 = wv_cnt;
    send_bits({1'b0, 40'h04_87654321}, 40);
    bus.data = 1'b1;
    cyc(3);
    bus.w_clk = 1'b1;
    bus.fq_ud = 1'b1;
    cyc(3);
    bus.w_clk = 1'b0;
    bus.fq_ud = 1'b0;
    cyc(6);
    chk("coin_freq", {8'd0, bus.freq_word}, 40'h87654321);
    chk("coin_pd", {35'd0, bus.phase, bus.pwr_down}, 40'd1);
    chk("coin_over", {39'd0, bus.err_over}, 40'd1);
    chk("coin_wv", 40'(wv_cnt - wv0), 40'd1);
    chk("coin_cnt", {32'd0, bus.frame_cnt}, 40'd4);

    // dds_reset mid-frame clears outputs, holds count and flags
    send_bits({1'b0, 40'hFF_FFFFFFFF}, 20);
    bus.dds_reset = 1'b1;
    cyc(4);
    bus.dds_reset = 1'b0;
    cyc(5);
    chk("dr_freq", {8'd0, bus.freq_word}, 40'd0);
    chk("dr_fields", {32'd0, bus.phase, bus.pwr_down, bus.ctrl}, 40'd0);
    chk("dr_cnt", {32'd0, bus.frame_cnt}, 40'd4);
    chk("dr_over_held", {39'd0, bus.err_over}, 40'd1);
    send_bits({1'b0, 40'h1A_A5A5A5A5}, 40);
    pulse_fq();
    chk("e_freq", {8'd0, bus.freq_word}, 40'hA5A5A5A5);
    chk("e_fields", {32'd0, bus.phase, bus.pwr_down, bus.ctrl}, {32'd0, 5'h03, 1'b0, 2'd2});
    chk("e_cnt", {32'd0, bus.frame_cnt}, 40'd5);

    // fq_ud with no bits: reload only
    wv0 = wv_cnt;
    rl0 = rl_cnt;
    pulse_fq();
    chk("rl_pulse", 40'(rl_cnt - rl0), 40'd1);
    chk("rl_wv", 40'(wv_cnt - wv0), 40'd0);
    chk("rl_freq", {8'd0, bus.freq_word}, 40'hA5A5A5A5);
    chk("rl_short", {39'd0, bus.err_short}, 40'd0);

    // asynchronous rst mid-frame, off the clock edge
    send_bits({1'b0, 40'hFF_FFFFFFFF}, 20);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_freq", {8'd0, bus.freq_word}, 40'd0);
    chk("arst_phase", {35'd0, bus.phase}, 40'd0);
    chk("arst_cnt", {32'd0, bus.frame_cnt}, 40'd0);
    chk("arst_over", {39'd0, bus.err_over}, 40'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // new error after rst, then err_clr removes it
    send_bits({1'b0, 40'h00_000003FF}, 10);
    pulse_fq();
    chk("post_short", {39'd0, bus.err_short}, 40'd1);
    chk("post_cnt", {32'd0, bus.frame_cnt}, 40'd0);
    pulse_err_clr();
    chk("post_clr", {39'd0, bus.err_short}, 40'd0);
    chk("never_both", 40'(both_cnt), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
